// File: rtl/dpram_port_master.sv
// Burst command master for one port of the 64x8 dual-port RAM: single-beat RAM accesses, 2-deep read pipeline.
// Optional macro DPRAM_MASTER_INIT_EN: zero-fill the whole RAM after reset before accepting commands.
module dpram_port_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
`ifdef DPRAM_MASTER_INIT_EN
    , S_INIT = 2'd3
`endif
  } state_t;

`ifdef DPRAM_MASTER_INIT_EN
  localparam state_t RST_STATE = S_INIT;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_data_d;
  logic                ram_we_d;
  logic                rd_issue;
  logic [1:0]          rd_pipe_q;
  logic                wr_beat;
`ifdef DPRAM_MASTER_INIT_EN
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
`endif

  assign wr_beat = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (wr_beat && (count_q == '0)) state_d = S_IDLE;
      S_READ:  if (count_q == '0) state_d = S_IDLE;
`ifdef DPRAM_MASTER_INIT_EN
      S_INIT:  if (init_cnt_q == '1) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; ram_we drops whenever no beat is issued
  always_comb begin
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    ram_addr_d = ram_addr;
    ram_data_d = ram_data;
    ram_we_d   = 1'b0;
    rd_issue   = 1'b0;
`ifdef DPRAM_MASTER_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          count_d    = cmd_len;
        end
      end
      S_WRITE: begin
        if (wr_beat) begin
          ram_addr_d = cur_addr_q;
          ram_data_d = wr_data;
          ram_we_d   = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          count_d    = count_q - LEN_W'(1);
        end
      end
      S_READ: begin
        ram_addr_d = cur_addr_q;
        rd_issue   = 1'b1;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        count_d    = count_q - LEN_W'(1);
      end
`ifdef DPRAM_MASTER_INIT_EN
      S_INIT: begin
        ram_addr_d = init_cnt_q;
        ram_data_d = '0;
        ram_we_d   = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
      end
`endif
      default: ;
    endcase
  end

  // Datapath and output registers; read data lands two edges after its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q <= '0;
      count_q    <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      rd_pipe_q  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      cmd_ready  <= (RST_STATE == S_IDLE);
      wr_ready   <= 1'b0;
      busy       <= (RST_STATE != S_IDLE);
`ifdef DPRAM_MASTER_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      ram_addr   <= ram_addr_d;
      ram_data   <= ram_data_d;
      ram_we     <= ram_we_d;
      rd_pipe_q  <= {rd_pipe_q[0], rd_issue};
      rd_valid   <= rd_pipe_q[1];
      if (rd_pipe_q[1]) rd_data <= ram_q;
      cmd_ready  <= (state_d == S_IDLE);
      wr_ready   <= (state_d == S_WRITE);
      busy       <= (state_d != S_IDLE);
`ifdef DPRAM_MASTER_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Scoreboard bench for dpram_port_master with a read-first RAM model on the port.
module tb_dpram_port_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, busy;
  logic [5:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic [7:0] ram_q;

  logic [7:0]  mem [64];
  logic [7:0]  exp_rd [$];
  logic [13:0] exp_wr [$];
  int checks = 0;
  int errors = 0;
  int rd_seen = 0;
  int wr_seen = 0;

  dpram_port_master #(.DATA_W(8), .ADDR_W(6), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM port
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read beats and RAM writes whenever the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        rd_seen++;
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got rd_data 0x%0h expected no beat", rd_data);
        end else chk("rd_data", {24'h0, rd_data}, {24'h0, exp_rd.pop_front()});
      end
      if (ram_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", ram_addr, ram_data);
        end else chk("ram_write", {18'h0, ram_addr, ram_data}, {18'h0, exp_wr.pop_front()});
      end
    end
  end

  task automatic check_reset();
    chk("rst_ram_addr", {26'h0, ram_addr}, 0);
    chk("rst_ram_data", {24'h0, ram_data}, 0);
    chk("rst_ram_we", {31'h0, ram_we}, 0);
    chk("rst_rd_data", {24'h0, rd_data}, 0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 0);
`ifdef DPRAM_MASTER_INIT_EN
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 0);
    chk("rst_busy", {31'h0, busy}, 1);
`else
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
`endif
  endtask

  task automatic after_release();
`ifdef DPRAM_MASTER_INIT_EN
    int n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("init_busy_cycles", n, 64);
`else
    @(negedge clk);
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 1);
    chk("idle_busy", {31'h0, busy}, 0);
`endif
  endtask

  task automatic push_init();
`ifdef DPRAM_MASTER_INIT_EN
    for (int i = 0; i < 64; i++) exp_wr.push_back({6'(i), 8'h00});
`endif
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [3:0] l);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'h0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", {31'h0, busy}, 1);
  endtask

  task automatic write_burst(input logic [5:0] a, input int n, input logic [31:0] dw, input int gap);
    logic [5:0] wa;
    logic [7:0] d;
    send_cmd(1'b1, a, 4'(n - 1));
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          @(negedge clk);
          chk("gap_ram_we", {31'h0, ram_we}, 0);
        end
      end
      wa = a + 6'(i);
      d  = dw[31 - 8*i -: 8];
      exp_wr.push_back({wa, d});
      wr_valid = 1'b1; wr_data = d;
      for (int k = 0; k < 50 && !wr_ready; k++) @(negedge clk);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("busy_after_write", {31'h0, busy}, 0);
  endtask

  task automatic read_burst(input logic [5:0] a, input logic [3:0] l, input logic [31:0] dw, input int nexp);
    for (int i = 0; i < nexp; i++) exp_rd.push_back(dw[31 - 8*i -: 8]);
    send_cmd(1'b0, a, l);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rd.size() != 0 || exp_wr.size() != 0) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("drain_rd_left", exp_rd.size(), 0);
    chk("drain_wr_left", exp_wr.size(), 0);
  endtask

  initial begin
    int base, snap, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset();
    push_init();
    rst_n = 1'b1;
    after_release();
    drain();
`ifdef DPRAM_MASTER_INIT_EN
    read_burst(6'h00, 4'd3, 32'h0000_0000, 4);
    drain();
`endif

    // Single write then single read with exact latency
    write_burst(6'h01, 1, 32'h3300_0000, 0);
    drain();
    read_burst(6'h01, 4'd0, 32'h3300_0000, 1);
    chk("lat_e0", {31'h0, rd_valid}, 0);
    @(negedge clk); chk("lat_e1", {31'h0, rd_valid}, 0);
    @(negedge clk); chk("lat_e2", {31'h0, rd_valid}, 0);
    @(negedge clk); chk("lat_e3", {31'h0, rd_valid}, 1);
    drain();

    // Wrapping burst 0x3E..0x01
    write_burst(6'h3E, 4, 32'h5566_7788, 0);
    drain();
    read_burst(6'h3E, 4'd3, 32'h5566_7788, 4);
    drain();

    // Write beats with a two-cycle stall after the first
    snap = wr_seen;
    write_burst(6'h10, 3, 32'hA1A2_A300, 2);
    drain();
    chk("gap_write_count", wr_seen - snap, 3);
    read_burst(6'h10, 4'd2, 32'hA1A2_A300, 3);
    drain();

    // Read immediately followed by a write to the same address
    write_burst(6'h02, 1, 32'h4400_0000, 0);
    drain();
    read_burst(6'h02, 4'd0, 32'h4400_0000, 1);
    write_burst(6'h02, 1, 32'h9900_0000, 0);
    drain();
    read_burst(6'h02, 4'd0, 32'h9900_0000, 1);
    drain();

    // Reset in the middle of an 8-beat read after three beats
    base = rd_seen;
    read_burst(6'h10, 4'd7, 32'hA1A2_A300, 3);
    n = 0;
    while (rd_seen < base + 3 && n < 100) begin @(posedge clk); n++; end
    chk("mid_rst_beats_before", rd_seen - base, 3);
    #2 rst_n = 1'b0;
    #1 check_reset();
    chk("mid_rst_rd_left", exp_rd.size(), 0);
    exp_rd.delete();
    repeat (2) @(negedge clk);
    check_reset();
    snap = rd_seen;
    push_init();
    rst_n = 1'b1;
    after_release();
    repeat (10) @(negedge clk);
    chk("no_stale_rd", rd_seen - snap, 0);
    drain();

`ifdef DPRAM_MASTER_INIT_EN
    read_burst(6'h3E, 4'd0, 32'h0000_0000, 1);
`else
    read_burst(6'h3E, 4'd0, 32'h5500_0000, 1);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
